// File: rtl/bomb_pkg.sv
// Shared types for the defusal puzzle: stage status codes, sequencer states, LFSR seed.
// Combinational helpers only; no latency, no backpressure.
package bomb_pkg;

  typedef enum logic [1:0] {
    FAILURE = 2'd0,
    SUCCESS = 2'd1,
    WAIT    = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SETTLE   = 3'd2,
    PLAY     = 3'd3,
    DEFUSED  = 3'd4,
    EXPLODED = 3'd5
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/bomb_sequencer_lfsr.sv
// 8-bit maximal-length LFSR shared with the stages; restarts at LFSR_SEED on reset.
// Advances every cycle, no backpressure; a nonzero seed keeps it out of the all-zero lock-up.
module lfsr
  import bomb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (!rst) value <= LFSR_SEED;
    else      value <= lfsr_next(value);
  end

endmodule

// File: rtl/bomb_sequencer.sv
// Game controller: walks the stages, reseeds/restarts each, counts strikes, runs the countdown.
// Outputs registered one cycle after the deciding input; no backpressure, inputs sampled every cycle.
module bomb_sequencer
  import bomb_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int MAX_STRIKES = 3,
  parameter int TIME_LIMIT  = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] stage_status,
  output logic [2:0] stage_sel,
  output logic       stage_rst,
  output logic [7:0] stage_seed,
  output logic [7:0] time_left,
  output logic [2:0] strikes,
  output logic       armed,
  output logic       defused,
  output logic       exploded
);

  localparam logic [2:0] LAST_STAGE   = 3'(NUM_STAGES - 1);
  localparam logic [2:0] STRIKE_LIMIT = 3'(MAX_STRIKES);
  localparam logic [7:0] TIME_INIT    = 8'(TIME_LIMIT);

  state_e     state;
  state_e     next_state;
  logic [7:0] lfsr_value;

  logic       is_success;
  logic       is_failure;
  logic       counting;
  logic       expire;
  logic       last_stage;
  logic       strike_out;

  logic [2:0] sel_d;
  logic [2:0] strikes_d;
  logic [7:0] seed_d;
  logic [7:0] time_d;
  logic       stage_rst_d;
  logic       armed_d;
  logic       defused_d;
  logic       exploded_d;

  lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  // Code 3 falls through both decodes and behaves as WAIT.
  assign is_success = (stage_status == SUCCESS);
  assign is_failure = (stage_status == FAILURE);
  assign counting   = (state == LOAD) || (state == SETTLE) || (state == PLAY);
  assign expire     = counting && tick && (time_left == 8'd1);
  assign last_stage = (stage_sel == LAST_STAGE);
  assign strike_out = ((strikes + 3'd1) == STRIKE_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // SUCCESS outranks expiry; FAILURE with expiry still detonates.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        next_state = expire ? EXPLODED : SETTLE;
      end
      SETTLE: begin
        next_state = expire ? EXPLODED : PLAY;
      end
      PLAY: begin
        if (is_success)      next_state = last_stage ? DEFUSED : LOAD;
        else if (is_failure) next_state = (strike_out || expire) ? EXPLODED : LOAD;
        else if (expire)     next_state = EXPLODED;
      end
      default: begin
        next_state = state;
      end
    endcase
  end

  always_comb begin
    sel_d       = stage_sel;
    strikes_d   = strikes;
    seed_d      = stage_seed;
    time_d      = time_left;
    stage_rst_d = !((next_state == LOAD) || (next_state == IDLE));
    armed_d     = (next_state == LOAD) || (next_state == SETTLE) || (next_state == PLAY);
    defused_d   = (next_state == DEFUSED);
    exploded_d  = (next_state == EXPLODED);

    if (state == IDLE) begin
      if (start) begin
        sel_d     = 3'd0;
        strikes_d = 3'd0;
        time_d    = TIME_INIT;
      end
    end else if (counting && tick && (time_left != 8'd0)) begin
      time_d = time_left - 8'd1;
    end

    if (state == PLAY) begin
      if (is_success && !last_stage) sel_d = stage_sel + 3'd1;
      if (!is_success && is_failure && (strikes != STRIKE_LIMIT)) strikes_d = strikes + 3'd1;
    end

    // Seed is captured on entry to LOAD so it is already valid while stage_rst is low.
    if (next_state == LOAD) seed_d = lfsr_value;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_sel  <= 3'd0;
      stage_rst  <= 1'b0;
      stage_seed <= 8'h00;
      time_left  <= TIME_INIT;
      strikes    <= 3'd0;
      armed      <= 1'b0;
      defused    <= 1'b0;
      exploded   <= 1'b0;
    end else begin
      stage_sel  <= sel_d;
      stage_rst  <= stage_rst_d;
      stage_seed <= seed_d;
      time_left  <= time_d;
      strikes    <= strikes_d;
      armed      <= armed_d;
      defused    <= defused_d;
      exploded   <= exploded_d;
    end
  end

endmodule

// File: tb/tb_bomb_sequencer.sv
// Directed bench for bomb_sequencer with NUM_STAGES=4, MAX_STRIKES=3, TIME_LIMIT=3.
module tb_bomb_sequencer;

  localparam logic [1:0] S_FAILURE = 2'd0;
  localparam logic [1:0] S_SUCCESS = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] stage_status = 2'd2;
  logic [2:0] stage_sel;
  logic       stage_rst;
  logic [7:0] stage_seed;
  logic [7:0] time_left;
  logic [2:0] strikes;
  logic       armed;
  logic       defused;
  logic       exploded;

  int n_checks = 0;
  int n_pass   = 0;

  // LFSR values latched at loads issued on cycles 1, 4, 7, 10 after a reset edge.
  logic [7:0] seed_tab [4];

  bomb_sequencer #(
    .NUM_STAGES  (4),
    .MAX_STRIKES (3),
    .TIME_LIMIT  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tick         (tick),
    .stage_status (stage_status),
    .stage_sel    (stage_sel),
    .stage_rst    (stage_rst),
    .stage_seed   (stage_seed),
    .time_left    (time_left),
    .strikes      (strikes),
    .armed        (armed),
    .defused      (defused),
    .exploded     (exploded)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; tick = 1'b0; stage_status = S_WAIT;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (stage_sel !== 3'd0) $display("FAIL reset_sel got=%0d want=0", stage_sel); else n_pass++;
    n_checks++; if (stage_rst !== 1'b0) $display("FAIL reset_stage_rst got=%b want=0", stage_rst); else n_pass++;
    n_checks++; if (stage_seed !== 8'h00) $display("FAIL reset_seed got=%h want=00", stage_seed); else n_pass++;
    n_checks++; if (time_left !== 8'd3) $display("FAIL reset_time got=%0d want=3", time_left); else n_pass++;
    n_checks++; if (strikes !== 3'd0) $display("FAIL reset_strikes got=%0d want=0", strikes); else n_pass++;
    n_checks++; if (armed !== 1'b0) $display("FAIL reset_armed got=%b want=0", armed); else n_pass++;
    n_checks++; if (defused !== 1'b0) $display("FAIL reset_defused got=%b want=0", defused); else n_pass++;
    n_checks++; if (exploded !== 1'b0) $display("FAIL reset_exploded got=%b want=0", exploded); else n_pass++;
  endtask

  task automatic test_defuse();
    logic exp_rst;
    do_reset();
    rst = 1'b1; start = 1'b1; stage_status = S_SUCCESS;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      start = 1'b0;
      exp_rst = !(c == 1 || c == 4 || c == 7 || c == 10);
      n_checks++; if (stage_rst !== exp_rst) $display("FAIL defuse_stage_rst c=%0d got=%b want=%b", c, stage_rst, exp_rst); else n_pass++;
      if (!exp_rst) begin
        n_checks++; if (stage_sel !== 3'((c - 1) / 3)) $display("FAIL defuse_sel c=%0d got=%0d want=%0d", c, stage_sel, (c - 1) / 3); else n_pass++;
        n_checks++; if (stage_seed !== seed_tab[(c - 1) / 3]) $display("FAIL defuse_seed c=%0d got=%h want=%h", c, stage_seed, seed_tab[(c - 1) / 3]); else n_pass++;
      end
      if (c == 12) begin
        n_checks++; if (defused !== 1'b0 || armed !== 1'b1) $display("FAIL defuse_early c=12 defused=%b armed=%b want 0/1", defused, armed); else n_pass++;
      end
    end
    n_checks++; if (defused !== 1'b1) $display("FAIL defuse_flag got=%b want=1", defused); else n_pass++;
    n_checks++; if (exploded !== 1'b0) $display("FAIL defuse_exploded got=%b want=0", exploded); else n_pass++;
    n_checks++; if (strikes !== 3'd0) $display("FAIL defuse_strikes got=%0d want=0", strikes); else n_pass++;
    n_checks++; if (armed !== 1'b0) $display("FAIL defuse_armed got=%b want=0", armed); else n_pass++;
    // Terminal: start and tick must not disturb anything.
    start = 1'b1; tick = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_checks++; if (defused !== 1'b1 || stage_sel !== 3'd3 || time_left !== 8'd3 || stage_rst !== 1'b1)
        $display("FAIL defuse_hold c=%0d defused=%b sel=%0d time=%0d stage_rst=%b want 1/3/3/1", c, defused, stage_sel, time_left, stage_rst); else n_pass++;
    end
    start = 1'b0; tick = 1'b0;
  endtask

  task automatic test_fail_explode();
    do_reset();
    rst = 1'b1; start = 1'b1; stage_status = S_SUCCESS;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      start = 1'b0;
      case (c)
        4: begin
          n_checks++; if (stage_sel !== 3'd1 || stage_rst !== 1'b0) $display("FAIL strike_load1 sel=%0d stage_rst=%b want 1/0", stage_sel, stage_rst); else n_pass++;
          stage_status = S_FAILURE;
        end
        7: begin
          n_checks++; if (strikes !== 3'd1 || stage_rst !== 1'b0 || stage_sel !== 3'd1) $display("FAIL strike_reload1 strikes=%0d stage_rst=%b sel=%0d want 1/0/1", strikes, stage_rst, stage_sel); else n_pass++;
          n_checks++; if (stage_seed !== 8'h53) $display("FAIL strike_seed1 got=%h want=53", stage_seed); else n_pass++;
        end
        10: begin
          n_checks++; if (strikes !== 3'd2 || stage_rst !== 1'b0 || stage_sel !== 3'd1) $display("FAIL strike_reload2 strikes=%0d stage_rst=%b sel=%0d want 2/0/1", strikes, stage_rst, stage_sel); else n_pass++;
          n_checks++; if (stage_seed !== 8'h9D) $display("FAIL strike_seed2 got=%h want=9d", stage_seed); else n_pass++;
        end
        12: begin
          n_checks++; if (exploded !== 1'b0 || armed !== 1'b1) $display("FAIL strike_early exploded=%b armed=%b want 0/1", exploded, armed); else n_pass++;
        end
        13: begin
          n_checks++; if (exploded !== 1'b1 || defused !== 1'b0) $display("FAIL strike_exploded exploded=%b defused=%b want 1/0", exploded, defused); else n_pass++;
          n_checks++; if (strikes !== 3'd3) $display("FAIL strike_count got=%0d want=3", strikes); else n_pass++;
          n_checks++; if (armed !== 1'b0) $display("FAIL strike_armed got=%b want=0", armed); else n_pass++;
        end
        default: ;
      endcase
    end
    stage_status = S_SUCCESS; tick = 1'b1; start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_checks++; if (stage_sel !== 3'd1 || strikes !== 3'd3 || time_left !== 8'd3 || exploded !== 1'b1)
        $display("FAIL strike_frozen c=%0d sel=%0d strikes=%0d time=%0d exploded=%b want 1/3/3/1", c, stage_sel, strikes, time_left, exploded); else n_pass++;
    end
    tick = 1'b0; start = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] exp_t;
    do_reset();
    rst = 1'b1; start = 1'b1; stage_status = S_WAIT;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      start = 1'b0;
      exp_t = (c < 4) ? 8'd3 : (c < 6) ? 8'd2 : (c < 8) ? 8'd1 : 8'd0;
      n_checks++; if (time_left !== exp_t) $display("FAIL timeout_time c=%0d got=%0d want=%0d", c, time_left, exp_t); else n_pass++;
      n_checks++; if (exploded !== (c >= 8)) $display("FAIL timeout_exploded c=%0d got=%b want=%b", c, exploded, (c >= 8)); else n_pass++;
      tick = (c == 3 || c == 5 || c == 7);
    end
    tick = 1'b0;
  endtask

  task automatic test_simul_success();
    do_reset();
    rst = 1'b1; start = 1'b1; stage_status = S_SUCCESS;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      start = 1'b0;
      if (c == 12) begin
        n_checks++; if (time_left !== 8'd1 || stage_sel !== 3'd3) $display("FAIL simok_pre time=%0d sel=%0d want 1/3", time_left, stage_sel); else n_pass++;
      end
      tick = (c == 1 || c == 2 || c == 12);
    end
    n_checks++; if (defused !== 1'b1 || exploded !== 1'b0) $display("FAIL simok_outcome defused=%b exploded=%b want 1/0", defused, exploded); else n_pass++;
    n_checks++; if (time_left !== 8'd0) $display("FAIL simok_time got=%0d want=0", time_left); else n_pass++;
    tick = 1'b0;
  endtask

  task automatic test_simul_failure();
    do_reset();
    rst = 1'b1; start = 1'b1; stage_status = S_SUCCESS;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      start = 1'b0;
      if (c == 12) stage_status = S_FAILURE;
      if (c == 13) begin
        n_checks++; if (strikes !== 3'd1 || stage_sel !== 3'd3 || stage_rst !== 1'b0 || time_left !== 8'd1)
          $display("FAIL simfail_reload strikes=%0d sel=%0d stage_rst=%b time=%0d want 1/3/0/1", strikes, stage_sel, stage_rst, time_left); else n_pass++;
      end
      if (c == 15) begin
        n_checks++; if (exploded !== 1'b0) $display("FAIL simfail_early got=%b want=0", exploded); else n_pass++;
      end
      tick = (c == 1 || c == 2 || c == 15);
    end
    n_checks++; if (exploded !== 1'b1 || defused !== 1'b0) $display("FAIL simfail_outcome exploded=%b defused=%b want 1/0", exploded, defused); else n_pass++;
    n_checks++; if (strikes !== 3'd2) $display("FAIL simfail_strikes got=%0d want=2", strikes); else n_pass++;
    n_checks++; if (time_left !== 8'd0) $display("FAIL simfail_time got=%0d want=0", time_left); else n_pass++;
    tick = 1'b0;
  endtask

  task automatic test_reset_midgame();
    do_reset();
    rst = 1'b1; start = 1'b1; stage_status = S_SUCCESS;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      start = 1'b0;
      if (c == 1 || c == 4 || c == 7) begin
        n_checks++; if (stage_seed !== seed_tab[(c - 1) / 3]) $display("FAIL midrst_seed_run1 c=%0d got=%h want=%h", c, stage_seed, seed_tab[(c - 1) / 3]); else n_pass++;
      end
    end
    n_checks++; if (stage_sel !== 3'd2 || stage_rst !== 1'b1 || armed !== 1'b1) $display("FAIL midrst_play sel=%0d stage_rst=%b armed=%b want 2/1/1", stage_sel, stage_rst, armed); else n_pass++;
    rst = 1'b0; stage_status = S_WAIT;
    cyc();
    n_checks++; if (stage_sel !== 3'd0 || stage_rst !== 1'b0 || stage_seed !== 8'h00)
      $display("FAIL midrst_outputs sel=%0d stage_rst=%b seed=%h want 0/0/00", stage_sel, stage_rst, stage_seed); else n_pass++;
    n_checks++; if (time_left !== 8'd3 || strikes !== 3'd0 || armed !== 1'b0 || defused !== 1'b0 || exploded !== 1'b0)
      $display("FAIL midrst_flags time=%0d strikes=%0d armed=%b defused=%b exploded=%b want 3/0/0/0/0", time_left, strikes, armed, defused, exploded); else n_pass++;
    rst = 1'b1; start = 1'b1; stage_status = S_SUCCESS;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0;
      if (c == 1 || c == 4 || c == 7) begin
        n_checks++; if (stage_seed !== seed_tab[(c - 1) / 3]) $display("FAIL midrst_seed_run2 c=%0d got=%h want=%h", c, stage_seed, seed_tab[(c - 1) / 3]); else n_pass++;
      end
    end
  endtask

  task automatic test_settle_ignore();
    do_reset();
    rst = 1'b1; start = 1'b1; stage_status = S_WAIT;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0;
      case (c)
        3: begin
          n_checks++; if (strikes !== 3'd0 || stage_rst !== 1'b1 || stage_sel !== 3'd0)
            $display("FAIL settle_fail strikes=%0d stage_rst=%b sel=%0d want 0/1/0", strikes, stage_rst, stage_sel); else n_pass++;
        end
        4: begin
          n_checks++; if (stage_sel !== 3'd1 || stage_rst !== 1'b0) $display("FAIL settle_adv sel=%0d stage_rst=%b want 1/0", stage_sel, stage_rst); else n_pass++;
        end
        6, 7: begin
          n_checks++; if (stage_sel !== 3'd1 || stage_rst !== 1'b1 || strikes !== 3'd0)
            $display("FAIL settle_ok c=%0d sel=%0d stage_rst=%b strikes=%0d want 1/1/0", c, stage_sel, stage_rst, strikes); else n_pass++;
        end
        default: ;
      endcase
      stage_status = (c == 2) ? S_FAILURE : (c == 3 || c == 5) ? S_SUCCESS : S_WAIT;
    end
  endtask

  initial begin
    seed_tab[0] = 8'hA5;
    seed_tab[1] = 8'h2A;
    seed_tab[2] = 8'h53;
    seed_tab[3] = 8'h9D;
    test_reset();
    test_defuse();
    test_fail_explode();
    test_timeout();
    test_simul_success();
    test_simul_failure();
    test_reset_midgame();
    test_settle_ignore();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bomb_sequencer.md
# bomb_sequencer

Top-level game controller for the defusal puzzle. It steps through `NUM_STAGES` puzzle stages in order and reseeds and restarts each one. It counts strikes on stage failure and runs the countdown timer. It raises `defused` or `exploded` as the terminal outcome. It sits between the board inputs (start button, 1 Hz tick) and the bank of `stage` instances, whose 2-bit status it consumes through a mux selected by `stage_sel`.

## Interface
- `NUM_STAGES`, default 4: number of stages; 2..8.
- `MAX_STRIKES`, default 3: failures that detonate; 1..7.
- `TIME_LIMIT`, default 120: countdown start value in ticks; 1..255.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset, synchronous, active-low.
- `start` input, 1 bit: level; sampled only in IDLE.
- `tick` input, 1 bit: one-cycle pulse, nominally 1 Hz.
- `stage_status` input, 2 bit: status of the selected stage; FAILURE=0, SUCCESS=1, WAIT=2, 3 is treated as WAIT.
- `stage_sel` output, 3 bit: index of the active stage.
- `stage_rst` output, 1 bit: active-low restart to the selected stage.
- `stage_seed` output, 8 bit: seed for the selected stage's button pattern.
- `time_left` output, 8 bit: remaining ticks.
- `strikes` output, 3 bit: failures so far.
- `armed`, `defused`, `exploded` outputs, 1 bit each: outcome flags, registered.

## Operation
- FSM states are IDLE, LOAD, SETTLE, PLAY, DEFUSED, EXPLODED.
- Reset (`rst`=0) puts the block in IDLE.
  - `stage_sel`=0, `stage_rst`=0, `stage_seed`=8'h00, `time_left`=TIME_LIMIT, `strikes`=0, `armed`/`defused`/`exploded`=0.
  - LFSR returns to 8'hA5.
  - Reset applied in any state, mid-game included, takes effect at the next edge.
- IDLE, `start`=1: load `time_left`=TIME_LIMIT, `strikes`=0, `stage_sel`=0, `armed`=1, go to LOAD.
- LOAD (1 cycle): `stage_rst`=0, `stage_seed` latches the current LFSR value, go to SETTLE.
- SETTLE (1 cycle): `stage_rst`=1, `stage_status` is ignored, go to PLAY.
- PLAY: `stage_rst`=1. Each cycle evaluate, first match wins:
  1. SUCCESS on the last stage: go to DEFUSED.
  2. SUCCESS on any other stage: `stage_sel`+1, go to LOAD.
  3. FAILURE: `strikes`+1. If the new value equals MAX_STRIKES, go to EXPLODED; otherwise go to LOAD on the same `stage_sel`, which gives a fresh seed.
  4. Timer expiry (see below): go to EXPLODED.
  5. WAIT: stay in PLAY.
- Timer:
  - In LOAD, SETTLE and PLAY, `tick`=1 decrements `time_left`; it saturates at 0.
  - Expiry means `time_left`=1 and `tick`=1 in the same cycle, i.e. the value about to reach 0.
  - Expiry in LOAD or SETTLE goes to EXPLODED.
- Simultaneous events in PLAY:
  - SUCCESS together with expiry: SUCCESS wins. `time_left` still decrements to 0.
  - FAILURE together with expiry: EXPLODED. `strikes` still increments, capped at MAX_STRIKES.
- DEFUSED and EXPLODED are terminal until reset.
  - Both hold `armed`=0 and freeze `time_left`, `strikes` and `stage_sel`.
  - `stage_rst`=1; `start` is ignored.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle after reset, in every state.
  - Never zero.

## Timing
- All outputs are registered; state changes appear the cycle after the causing input is sampled.
- `start` to the first `stage_rst` low pulse: 1 cycle. `stage_rst` is low for exactly 1 cycle per LOAD.
- Stage change: SUCCESS sampled in cycle N gives LOAD (new `stage_sel`, `stage_rst`=0) in N+1, SETTLE in N+2, PLAY in N+3.
- `stage_seed` and `stage_sel` are stable from LOAD until the next LOAD.
- `defused`/`exploded` assert 1 cycle after the deciding event, and are mutually exclusive.

## Structure
- Shared package `bomb_pkg`:
  - Status codes FAILURE/SUCCESS/WAIT (2-bit).
  - FSM state enum.
  - LFSR reset seed 8'hA5.
- One sub-module, `lfsr`: 8-bit, `clk`/`rst`, output `value`. It is the same generator the stages use.
- The status mux sits outside this block.

## Test plan
- Reset, then `start`=1 with `stage_status` SUCCESS held after each SETTLE, NUM_STAGES=4 → `stage_sel` 0→1→2→3, four single-cycle `stage_rst` pulses, `defused`=1, `strikes`=0.
- FAILURE three times on stage 1, MAX_STRIKES=3 → two reloads with differing `stage_seed`, `strikes`=3, `exploded`=1, `stage_sel`=1 frozen.
- TIME_LIMIT=3, WAIT held, three `tick` pulses → `time_left` 3→2→1→0, `exploded`=1 one cycle after the third tick.
- Last stage: SUCCESS and final `tick` in the same cycle → `defused`=1, `exploded`=0, `time_left`=0. Repeat with FAILURE at `strikes`=1 and final tick → `exploded`=1, `strikes`=2.
- `rst`=0 during PLAY on stage 2 → next cycle IDLE, all outputs at reset values, `stage_seed`=8'h00. A subsequent `start` replays an identical seed sequence.
- FAILURE/SUCCESS presented during SETTLE → ignored: no strike, no advance.
